// File: rtl/result_serializer.sv
// Result serializer: buffers WIDTH x WIDTH result matrices captured on `done` in a
// DEPTH-deep matrix FIFO and streams them out one element per valid/ready handshake,
// row-major, tagged with row/col/last and a per-matrix sequence number.
module result_serializer #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned SEQ_W  = 8
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic                                      done,
    input  logic [0:WIDTH-1][0:WIDTH-1][DATA_W-1:0]   result,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [DATA_W-1:0]                         out_data,
    output logic [$clog2(WIDTH)-1:0]                  out_row,
    output logic [$clog2(WIDTH)-1:0]                  out_col,
    output logic                                      out_last,
    output logic [SEQ_W-1:0]                          out_seq,
    output logic                                      full,
    output logic                                      overflow,
    output logic [SEQ_W-1:0]                          drop_cnt
);

    localparam int unsigned NELEM = WIDTH * WIDTH;
    localparam int unsigned IDX_W = $clog2(NELEM);
    localparam int unsigned RC_W  = $clog2(WIDTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef logic [0:WIDTH-1][0:WIDTH-1][DATA_W-1:0] matrix_t;

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [SEQ_W-1:0]        seq_cnt_q, seq_cnt_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [RC_W-1:0]         row_q, row_d;
    logic [RC_W-1:0]         col_q, col_d;
    logic                    last_q, last_d;
    logic [SEQ_W-1:0]        oseq_q, oseq_d;
    logic                    overflow_q, overflow_d;
    logic [SEQ_W-1:0]        drop_q, drop_d;

    matrix_t                 mat_q [DEPTH];
    logic [SEQ_W-1:0]        mat_seq_q [DEPTH];

    logic                    hs;
    logic                    pop_last;
    logic                    capture;
    logic                    drop;
    logic                    bypass;
    matrix_t                 head_mat;
    logic [SEQ_W-1:0]        head_seq;
    logic [RC_W-1:0]         head_row;
    logic [RC_W-1:0]         head_col;

    // Next-state and registered-output computation for the stream FSM and FIFO bookkeeping.
    always_comb begin
        hs       = (state_q == StStream) && out_ready;
        pop_last = hs && last_q;
        // A matrix finishing its last beat frees its slot in the same cycle.
        capture  = done && ((count_q != CNT_W'(DEPTH)) || pop_last);
        drop     = done && !capture;

        count_d = count_q;
        if (capture && !pop_last) begin
            count_d = count_q + CNT_W'(1);
        end else if (!capture && pop_last) begin
            count_d = count_q - CNT_W'(1);
        end

        idx_d = idx_q;
        if (hs) begin
            idx_d = pop_last ? '0 : idx_q + IDX_W'(1);
        end

        rd_ptr_d   = pop_last ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d   = capture ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        seq_cnt_d  = capture ? seq_cnt_q + SEQ_W'(1) : seq_cnt_q;
        overflow_d = overflow_q | drop;
        drop_d     = (drop && (drop_q != '1)) ? drop_q + SEQ_W'(1) : drop_q;

        // The next head matrix is still on the input bus when it is captured this cycle.
        bypass   = capture && (wr_ptr_q == rd_ptr_d);
        head_mat = bypass ? result : mat_q[rd_ptr_d];
        head_seq = bypass ? seq_cnt_q : mat_seq_q[rd_ptr_d];
        head_row = idx_d[IDX_W-1:RC_W];
        head_col = idx_d[RC_W-1:0];

        state_d = StIdle;
        data_d  = '0;
        row_d   = '0;
        col_d   = '0;
        last_d  = 1'b0;
        oseq_d  = '0;
        if (count_d != '0) begin
            state_d = StStream;
            data_d  = head_mat[head_row][head_col];
            row_d   = head_row;
            col_d   = head_col;
            last_d  = (idx_d == IDX_W'(NELEM - 1));
            oseq_d  = head_seq;
        end
    end

    // Control state and registered outputs, synchronously cleared on reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            seq_cnt_q  <= '0;
            data_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            last_q     <= 1'b0;
            oseq_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            seq_cnt_q  <= seq_cnt_d;
            data_q     <= data_d;
            row_q      <= row_d;
            col_q      <= col_d;
            last_q     <= last_d;
            oseq_q     <= oseq_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Matrix storage; contents need no reset since occupancy is tracked by count_q.
    always_ff @(posedge CLK) begin
        if (capture && !RST) begin
            mat_q[wr_ptr_q]     <= result;
            mat_seq_q[wr_ptr_q] <= seq_cnt_q;
        end
    end

    assign out_valid = (state_q == StStream);
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = last_q;
    assign out_seq   = oseq_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: a queue-of-matrices reference model predicts
// every output each cycle under directed and randomized done/out_ready stimulus.
module tb_result_serializer;

    localparam int WIDTH  = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int SEQ_W  = 8;
    localparam int NELEM  = WIDTH * WIDTH;

    logic                                    CLK = 1'b0;
    logic                                    RST;
    logic                                    done;
    logic [0:WIDTH-1][0:WIDTH-1][DATA_W-1:0] result;
    logic                                    out_valid;
    logic                                    out_ready;
    logic [DATA_W-1:0]                       out_data;
    logic [1:0]                              out_row;
    logic [1:0]                              out_col;
    logic                                    out_last;
    logic [SEQ_W-1:0]                        out_seq;
    logic                                    full;
    logic                                    overflow;
    logic [SEQ_W-1:0]                        drop_cnt;

    result_serializer #(
        .WIDTH  (WIDTH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .SEQ_W  (SEQ_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .done      (done),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .out_seq   (out_seq),
        .full      (full),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [SEQ_W-1:0]              seq;
        logic [NELEM-1:0][DATA_W-1:0]  e;
    } mat_t;

    // Reference model: stored matrices in arrival order, head element index, counters.
    mat_t             mq[$];
    int               m_idx;
    logic [SEQ_W-1:0] m_seq;
    logic             m_ovf;
    logic [SEQ_W-1:0] m_drop;
    logic             m_rst;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    // Advance the model by one clock using the inputs as they were at the edge.
    task automatic model_step();
        bit valid, hs, pop_last, cap;
        mat_t m;
        if (RST) begin
            mq.delete();
            m_idx  = 0;
            m_seq  = '0;
            m_ovf  = 1'b0;
            m_drop = '0;
            m_rst  = 1'b1;
        end else begin
            m_rst    = 1'b0;
            valid    = (mq.size() > 0);
            hs       = valid && out_ready;
            pop_last = hs && (m_idx == NELEM - 1);
            cap      = done && ((mq.size() < DEPTH) || pop_last);
            if (hs) begin
                if (pop_last) begin
                    mq.delete(0);
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
            if (cap) begin
                m.seq = m_seq;
                for (int i = 0; i < NELEM; i++) m.e[i] = result[i / WIDTH][i % WIDTH];
                mq.push_back(m);
                m_seq++;
            end else if (done) begin
                m_ovf = 1'b1;
                if (m_drop != '1) m_drop++;
            end
        end
    endtask

    task automatic compare();
        check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        check("full", 64'(full), 64'(mq.size() == DEPTH));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (mq.size() > 0) begin
            check("out_data", 64'(out_data), 64'(mq[0].e[m_idx]));
            check("out_row", 64'(out_row), 64'(m_idx / WIDTH));
            check("out_col", 64'(out_col), 64'(m_idx % WIDTH));
            check("out_last", 64'(out_last), 64'(m_idx == NELEM - 1));
            check("out_seq", 64'(out_seq), 64'(mq[0].seq));
        end else if (m_rst) begin
            check("rst_data", 64'(out_data), 64'(0));
            check("rst_row", 64'(out_row), 64'(0));
            check("rst_col", 64'(out_col), 64'(0));
            check("rst_last", 64'(out_last), 64'(0));
            check("rst_seq", 64'(out_seq), 64'(0));
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        compare();
    endtask

    task automatic set_ramp(input int base);
        for (int r = 0; r < WIDTH; r++)
            for (int c = 0; c < WIDTH; c++)
                result[r][c] = 32'(base + r * WIDTH + c);
    endtask

    task automatic set_rand();
        int sel;
        for (int r = 0; r < WIDTH; r++)
            for (int c = 0; c < WIDTH; c++) begin
                sel = int'($urandom_range(0, 7));
                case (sel)
                    0:       result[r][c] = 32'h8000_0000;
                    1:       result[r][c] = 32'h7FFF_FFFF;
                    2:       result[r][c] = 32'hFFFF_FFFF;
                    default: result[r][c] = $urandom;
                endcase
            end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        cycle();
        done = 1'b0;
    endtask

    initial begin
        RST       = 1'b1;
        done      = 1'b0;
        out_ready = 1'b1;
        result    = '0;
        m_idx     = 0;
        m_seq     = '0;
        m_ovf     = 1'b0;
        m_drop    = '0;
        m_rst     = 1'b1;

        // Reset, then a single ramp matrix -8..7 with ready held high.
        cycle();
        do_reset();
        set_ramp(-8);
        pulse_done();
        repeat (20) cycle();

        // Ready toggling 1,0,0,1 with extreme values in the matrix.
        set_rand();
        result[0][0] = 32'h8000_0000;
        result[0][1] = 32'h7FFF_FFFF;
        result[3][3] = 32'h8000_0000;
        pulse_done();
        for (int k = 0; k < 64; k++) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            cycle();
        end
        out_ready = 1'b1;
        repeat (20) cycle();

        // Three done pulses while stalled: two stored, third dropped; then drain.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_rand();
            pulse_done();
            cycle();
        end
        out_ready = 1'b1;
        repeat (40) cycle();

        // Full buffer, done coincides with the last-beat handshake of the head matrix.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_rand();
            pulse_done();
        end
        out_ready = 1'b1;
        repeat (15) cycle();
        set_ramp(100);
        pulse_done();
        repeat (40) cycle();

        // Reset mid-stream with two matrices stored; a done in the reset cycle is ignored.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_rand();
            pulse_done();
        end
        out_ready = 1'b1;
        repeat (7) cycle();
        RST  = 1'b1;
        done = 1'b1;
        cycle();
        RST  = 1'b0;
        done = 1'b0;
        repeat (2) cycle();
        set_ramp(-8);
        pulse_done();
        repeat (20) cycle();

        // 300 matrices at the sustainable spacing; sequence number wraps.
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            set_rand();
            pulse_done();
            repeat (NELEM - 1) cycle();
        end
        repeat (20) cycle();

        // Random done/ready traffic, including drops.
        for (int i = 0; i < 1500; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            done      = ($urandom_range(0, 9) == 0);
            if (done) set_rand();
            cycle();
        end
        done      = 1'b0;
        out_ready = 1'b1;
        repeat (40) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
